// File: rtl/scroll_sequencer_if.sv
// scroll_sequencer_if: FIFO read port between the receive FIFO and scroll_sequencer.
//   rd_en      - read strobe, one cycle per byte (driven by the sequencer)
//   rd_data    - FIFO read data, valid the cycle after rd_en (driven by the FIFO)
//   fifo_empty - FIFO empty flag (driven by the FIFO)
// Modports: master = sequencer side, slave = FIFO side.
`timescale 1ns/1ps

interface scroll_sequencer_if;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       fifo_empty;

  modport master (
    output rd_en,
    input  rd_data,
    input  fifo_empty
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output fifo_empty
  );
endinterface

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: read-side controller for the receive FIFO. Each rising edge of the
// rate-divided i_tick_clk (synchronized into clk) pulls one byte from the FIFO, decodes it
// from ASCII to a BCD digit and shifts it into the display register at nibble 0.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   i_start     - level enable: 1 = scroll, 0 = stop
//   i_tick_clk  - divided clock, asynchronous to clk
//   fifo        - FIFO read port (scroll_sequencer_if.master)
//   o_digits    - display register, nibble 0 is the newest digit
//   o_valid     - one-cycle pulse on every o_digits update
//   o_busy      - high whenever the FSM is not idle
//   o_err       - sticky flag, set by any non-digit byte, cleared only by reset
//
// Build option: define SCROLL_BLANK_FILL_EN to shift BLANK_CODE in on a tick that finds
// the FIFO empty, so the display scrolls out to blank. Undefined: such ticks are ignored.
`timescale 1ns/1ps

module scroll_sequencer #(
  parameter int unsigned DIGITS     = 4,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_tick_clk,
  scroll_sequencer_if.master      fifo,
  output logic [4*DIGITS-1:0]     o_digits,
  output logic                    o_valid,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaitTick = 2'd1;
  localparam logic [1:0] StRead     = 2'd2;
  localparam logic [1:0] StLoad     = 2'd3;

  logic [1:0]          state_q, state_d;
  // [0],[1]: two-flop synchronizer; [2]: previous value for rising-edge detection.
  logic [2:0]          sync_q, sync_d;
  // Marks which sync stages hold a real sample since reset, so a level that is already
  // high at reset release is not mistaken for a rising edge against the reset value.
  logic [2:0]          primed_q, primed_d;
  logic                tick;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                rd_en_q, rd_en_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                rd_is_digit;
  logic [3:0]          rd_nibble;

  always_comb begin
    sync_d   = {sync_q[1:0], i_tick_clk};
    primed_d = {primed_q[1:0], 1'b1};
    tick     = sync_q[1] & ~sync_q[2] & primed_q[2];
  end

  always_comb begin
    rd_is_digit = (fifo.rd_data >= 8'h30) && (fifo.rd_data <= 8'h39);
    rd_nibble   = rd_is_digit ? fifo.rd_data[3:0] : BLANK_CODE;
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (i_start) state_d = StWaitTick;
      end
      StWaitTick: begin
        // i_start has priority over a coincident tick.
        if (!i_start) begin
          state_d = StIdle;
        end else if (tick) begin
          if (!fifo.fifo_empty) begin
            state_d = StRead;
          end else begin
`ifdef SCROLL_BLANK_FILL_EN
            digits_d      = digits_q << 4;
            digits_d[3:0] = BLANK_CODE;
            valid_d       = 1'b1;
`endif
          end
        end
      end
      StRead: begin
        state_d = StLoad;
      end
      StLoad: begin
        // A read already issued always completes, even if i_start has dropped.
        digits_d      = digits_q << 4;
        digits_d[3:0] = rd_nibble;
        valid_d       = 1'b1;
        if (!rd_is_digit) err_d = 1'b1;
        state_d = i_start ? StWaitTick : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Outputs are registered from the next state so they line up with the state change.
    rd_en_d = (state_d == StRead);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sync_q   <= 3'b000;
      primed_q <= 3'b000;
      digits_q <= {DIGITS{BLANK_CODE}};
      rd_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      primed_q <= primed_d;
      digits_q <= digits_d;
      rd_en_q  <= rd_en_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign fifo.rd_en = rd_en_q;
  assign o_digits   = digits_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: self-checking bench for scroll_sequencer (DIGITS=4, BLANK_CODE=F).
// A FIFO model answers read strobes; expected display values are queued when bytes are
// loaded and compared by a monitor on every o_valid pulse.
`timescale 1ns/1ps

module tb_scroll_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        i_tick_clk;
  logic [15:0] o_digits;
  logic        o_valid;
  logic        o_busy;
  logic        o_err;

  scroll_sequencer_if bus ();

  scroll_sequencer #(
    .DIGITS     (4),
    .BLANK_CODE (4'hF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_tick_clk (i_tick_clk),
    .fifo       (bus),
    .o_digits   (o_digits),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          rd_cnt      = 0;
  int          valid_cnt   = 0;
  logic        rd_prev     = 1'b0;
  logic [7:0]  fq[$];
  logic [15:0] exp_q[$];
  logic [7:0]  fifo_byte;
  logic [15:0] mon_exp;

  // FIFO model: data appears the cycle after a sampled read strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data    <= 8'h00;
      bus.fifo_empty <= 1'b1;
    end else begin
      if (bus.rd_en && fq.size() > 0) begin
        fifo_byte   = fq.pop_front();
        bus.rd_data <= fifo_byte;
      end
      bus.fifo_empty <= (fq.size() == 0);
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        valid_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: o_digits=%h with no expected value queued", o_digits);
        end else begin
          mon_exp = exp_q.pop_front();
          if (o_digits !== mon_exp) begin
            miscompares++;
            $display("FAIL digits_update: got %h expected %h", o_digits, mon_exp);
          end
        end
      end
      if (bus.rd_en) begin
        rd_cnt++;
        vectors++;
        if (rd_prev) begin
          miscompares++;
          $display("FAIL rd_en_width: got high for 2+ cycles expected single-cycle pulse");
        end
      end
      rd_prev = bus.rd_en;
    end else begin
      rd_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_tick_clk = 1'b0;
    fq.delete();
    exp_q.delete();
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(4);
  endtask

  // Pulse i_tick_clk high for hi cycles then low for lo; lat = first negedge with rd_en.
  task automatic do_tick(input int hi, input int lo, output int lat);
    lat        = -1;
    i_tick_clk = 1'b1;
    for (int k = 1; k <= hi + lo; k++) begin
      @(negedge clk);
      if (bus.rd_en && lat < 0) lat = k;
      if (k == hi) i_tick_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    int rd_snap;
    bit found;
    rst_n = 1'b0; i_start = 1'b0; i_tick_clk = 1'b0;
    wait_neg(1);
    vectors++;
    if (o_digits !== 16'hFFFF) begin
      miscompares++; $display("FAIL reset_digits: got %h expected ffff", o_digits);
    end
    vectors++;
    if ({bus.rd_en, o_valid, o_busy, o_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got rd/valid/busy/err=%b expected 0000",
               {bus.rd_en, o_valid, o_busy, o_err});
    end
    rst_n = 1'b1;
    wait_neg(3);
    i_start = 1'b1;
    fq.push_back("7");
    wait_neg(3);
    i_tick_clk = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.rd_en) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL reset_reach_read: got no rd_en expected read within 10 cycles");
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.rd_en, o_busy, o_valid} !== 3'b000 || o_digits !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL reset_mid_read: got rd/busy/valid=%b digits=%h expected 000 ffff",
               {bus.rd_en, o_busy, o_valid}, o_digits);
    end
    rd_snap = rd_cnt;
    fq.delete();
    fq.push_back("7");
    wait_neg(2);
    rst_n = 1'b1;  // i_tick_clk still high at release
    wait_neg(10);
    vectors++;
    if (rd_cnt !== rd_snap) begin
      miscompares++;
      $display("FAIL reset_high_tick: got %0d reads expected 0", rd_cnt - rd_snap);
    end
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++; $display("FAIL reset_busy_after: got %b expected 1", o_busy);
    end
    i_tick_clk = 1'b0;
    i_start    = 1'b0;
    fq.delete();
    wait_neg(3);
  endtask

  task automatic test_normal_scroll();
    int lat, rd_snap, v_snap;
    do_reset();
    rd_snap = rd_cnt; v_snap = valid_cnt;
    i_start = 1'b1;
    fq.push_back("1"); fq.push_back("2"); fq.push_back("3"); fq.push_back("4");
    exp_q.push_back(16'hFFF1); exp_q.push_back(16'hFF12);
    exp_q.push_back(16'hF123); exp_q.push_back(16'h1234);
    wait_neg(3);
    for (int t = 0; t < 4; t++) begin
      do_tick(4, 4, lat);
      vectors++;
      if (lat !== 3) begin
        miscompares++;
        $display("FAIL rd_latency[%0d]: got %0d cycles expected 3", t, lat);
      end
    end
    wait_neg(2);
    vectors++;
    if (o_digits !== 16'h1234) begin
      miscompares++; $display("FAIL scroll_final: got %h expected 1234", o_digits);
    end
    vectors++;
    if (valid_cnt - v_snap !== 4 || rd_cnt - rd_snap !== 4) begin
      miscompares++;
      $display("FAIL scroll_counts: got valid=%0d rd=%0d expected 4 4",
               valid_cnt - v_snap, rd_cnt - rd_snap);
    end
    vectors++;
    if (o_err !== 1'b0) begin
      miscompares++; $display("FAIL scroll_err: got %b expected 0", o_err);
    end
  endtask

  task automatic test_invalid_byte();
    int lat;
    fq.push_back(8'h41);
    exp_q.push_back(16'h234F);
    do_tick(4, 4, lat);
    vectors++;
    if (o_err !== 1'b1 || o_digits !== 16'h234F) begin
      miscompares++;
      $display("FAIL invalid_byte: got err=%b digits=%h expected 1 234f", o_err, o_digits);
    end
    fq.push_back("5");
    exp_q.push_back(16'h34F5);
    do_tick(4, 4, lat);
    vectors++;
    if (o_err !== 1'b1 || o_digits !== 16'h34F5) begin
      miscompares++;
      $display("FAIL err_sticky: got err=%b digits=%h expected 1 34f5", o_err, o_digits);
    end
  endtask

  task automatic test_empty_fifo();
    int lat, rd_snap, v_snap;
    do_reset();
    i_start = 1'b1;
    fq.push_back("1"); fq.push_back("2"); fq.push_back("3"); fq.push_back("4");
    exp_q.push_back(16'hFFF1); exp_q.push_back(16'hFF12);
    exp_q.push_back(16'hF123); exp_q.push_back(16'h1234);
    wait_neg(3);
    for (int t = 0; t < 4; t++) do_tick(4, 4, lat);
    wait_neg(2);
    rd_snap = rd_cnt; v_snap = valid_cnt;
`ifdef SCROLL_BLANK_FILL_EN
    exp_q.push_back(16'h234F); exp_q.push_back(16'h34FF);
`endif
    for (int t = 0; t < 2; t++) begin
      do_tick(4, 4, lat);
      vectors++;
      if (lat !== -1) begin
        miscompares++; $display("FAIL empty_no_read[%0d]: got rd at %0d expected none", t, lat);
      end
    end
    wait_neg(2);
    vectors++;
    if (rd_cnt !== rd_snap) begin
      miscompares++; $display("FAIL empty_rd_count: got %0d expected 0", rd_cnt - rd_snap);
    end
`ifdef SCROLL_BLANK_FILL_EN
    vectors++;
    if (o_digits !== 16'h34FF || valid_cnt - v_snap !== 2) begin
      miscompares++;
      $display("FAIL empty_blank_fill: got %h valid=%0d expected 34ff 2",
               o_digits, valid_cnt - v_snap);
    end
`else
    vectors++;
    if (o_digits !== 16'h1234 || valid_cnt - v_snap !== 0) begin
      miscompares++;
      $display("FAIL empty_hold: got %h valid=%0d expected 1234 0", o_digits, valid_cnt - v_snap);
    end
`endif
    vectors++;
    if (o_err !== 1'b0) begin
      miscompares++; $display("FAIL empty_err: got %b expected 0", o_err);
    end
  endtask

  task automatic test_stop_mid_read();
    int lat, rd_snap, v_snap;
    bit found;
    do_reset();
    i_start = 1'b1;
    fq.push_back("9");
    exp_q.push_back(16'hFFF9);
    v_snap = valid_cnt;
    wait_neg(3);
    i_tick_clk = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.rd_en) found = 1'b1;
    end
    i_start = 1'b0;  // drop during the READ cycle
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL stop_reach_read: got no rd_en expected read within 10 cycles");
    end
    wait_neg(4);
    i_tick_clk = 1'b0;
    wait_neg(3);
    vectors++;
    if (valid_cnt - v_snap !== 1 || o_digits !== 16'hFFF9 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_completes: got valid=%0d digits=%h busy=%b expected 1 fff9 0",
               valid_cnt - v_snap, o_digits, o_busy);
    end
    fq.push_back("8");
    wait_neg(2);
    rd_snap = rd_cnt;
    for (int t = 0; t < 2; t++) do_tick(4, 4, lat);
    vectors++;
    if (rd_cnt !== rd_snap) begin
      miscompares++; $display("FAIL stop_idle_ticks: got %0d reads expected 0", rd_cnt - rd_snap);
    end
    fq.delete();
  endtask

  task automatic test_collision();
    int rd_snap, v_snap;
    do_reset();
    i_start = 1'b1;
    fq.push_back("7");
    wait_neg(3);
    rd_snap = rd_cnt; v_snap = valid_cnt;
    i_tick_clk = 1'b1;
    wait_neg(2);
    i_start = 1'b0;  // falls in the cycle the tick is acted on
    wait_neg(2);
    i_tick_clk = 1'b0;
    wait_neg(6);
    vectors++;
    if (rd_cnt !== rd_snap || valid_cnt !== v_snap || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_collision: got rd=%0d valid=%0d busy=%b expected 0 0 0",
               rd_cnt - rd_snap, valid_cnt - v_snap, o_busy);
    end
  endtask

  // Rising edges every 2 clk: every second tick lands in LOAD and is dropped.
  task automatic test_back_to_back();
    int rd_snap, v_snap;
    do_reset();
    i_start = 1'b1;
    fq.push_back("1"); fq.push_back("2"); fq.push_back("3"); fq.push_back("4");
    exp_q.push_back(16'hFFF1); exp_q.push_back(16'hFF12);
    wait_neg(3);
    rd_snap = rd_cnt; v_snap = valid_cnt;
    for (int t = 0; t < 4; t++) begin
      i_tick_clk = 1'b1;
      @(negedge clk);
      i_tick_clk = 1'b0;
      @(negedge clk);
    end
    wait_neg(8);
    vectors++;
    if (rd_cnt - rd_snap !== 2 || valid_cnt - v_snap !== 2) begin
      miscompares++;
      $display("FAIL fast_ticks: got rd=%0d valid=%0d expected 2 2",
               rd_cnt - rd_snap, valid_cnt - v_snap);
    end
    vectors++;
    if (o_digits !== 16'hFF12) begin
      miscompares++; $display("FAIL fast_digits: got %h expected ff12", o_digits);
    end
    i_start = 1'b0;
    fq.delete();
    wait_neg(3);
  endtask

  initial begin
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_tick_clk = 1'b0;
    test_reset();
    test_normal_scroll();
    test_invalid_byte();
    test_empty_fifo();
    test_stop_mid_read();
    test_collision();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
